// File: rtl/iq_phase_det_if.sv
// iq_phase_det_if: I/Q sample stream in, phase/frequency results out.
// mag exists only when IQ_MAG_EN is defined.
interface iq_phase_det_if;
  logic               stb;
  logic               iq;
  logic signed [17:0] dixy;
  logic [15:0]        phs;
  logic [31:0]        frq;
  logic               rdy;
  logic               fvld;
  logic               busy;
`ifdef IQ_MAG_EN
  logic [18:0]        mag;

  modport master (
    output stb, iq, dixy,
    input  phs, frq, rdy, fvld, busy, mag
  );
  modport slave (
    input  stb, iq, dixy,
    output phs, frq, rdy, fvld, busy, mag
  );
`else
  modport master (
    output stb, iq, dixy,
    input  phs, frq, rdy, fvld, busy
  );
  modport slave (
    input  stb, iq, dixy,
    output phs, frq, rdy, fvld, busy
  );
`endif
endinterface

// File: rtl/iq_phase_det.sv
// iq_phase_det: I/Q phase + frequency detector, iterative vectoring CORDIC.
// Define IQ_MAG_EN to add the magnitude output mag.
module iq_phase_det #(
  parameter int ITER    = 16,
  parameter int DECLOG2 = 4
) (
  input logic           dclk,
  input logic           rst,
  iq_phase_det_if.slave bus
);
  localparam int W = 22;

  typedef enum logic [1:0] {IDLE, PRE, ROT, OUT} state_t;

  state_t             state;
  logic signed [17:0] hold_i;
  logic signed [17:0] pair_i;
  logic signed [17:0] pair_q;
  logic               hold_v;
  logic [DECLOG2-1:0] cnt;
  logic [4:0]         k;
  logic signed [W-1:0] x;
  logic signed [W-1:0] y;
  logic signed [W-1:0] ie;
  logic signed [W-1:0] qe;
  logic [15:0]        z;
  logic [15:0]        phs;
  logic [15:0]        d;
  logic [31:0]        frq;
  logic               rdy;
  logic               fvld;
  logic               busy;
  logic               have_prev;
  logic               pair;
`ifdef IQ_MAG_EN
  logic [18:0]        mag;
`endif

  function automatic logic [15:0] atan_lut(input logic [4:0] n);
    case (n)
      5'd0:    atan_lut = 16'd8192;
      5'd1:    atan_lut = 16'd4836;
      5'd2:    atan_lut = 16'd2555;
      5'd3:    atan_lut = 16'd1297;
      5'd4:    atan_lut = 16'd651;
      5'd5:    atan_lut = 16'd326;
      5'd6:    atan_lut = 16'd163;
      5'd7:    atan_lut = 16'd81;
      5'd8:    atan_lut = 16'd41;
      5'd9:    atan_lut = 16'd20;
      5'd10:   atan_lut = 16'd10;
      5'd11:   atan_lut = 16'd5;
      5'd12:   atan_lut = 16'd3;
      5'd13:   atan_lut = 16'd1;
      5'd14:   atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction

  assign pair = bus.stb & ~bus.iq & hold_v;

  // two guard LSBs below the sample, two headroom bits for CORDIC gain
  assign ie = {{(W-20){pair_i[17]}}, pair_i, 2'b00};
  assign qe = {{(W-20){pair_q[17]}}, pair_q, 2'b00};
  assign d  = z - phs;

  assign bus.phs  = phs;
  assign bus.frq  = frq;
  assign bus.rdy  = rdy;
  assign bus.fvld = fvld;
  assign bus.busy = busy;
`ifdef IQ_MAG_EN
  assign bus.mag  = mag;
`endif

  always_ff @(posedge dclk) begin
    if (rst) begin
      state     <= IDLE;
      hold_i    <= '0;
      hold_v    <= 1'b0;
      pair_i    <= '0;
      pair_q    <= '0;
      cnt       <= '0;
      k         <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      phs       <= '0;
      frq       <= '0;
      rdy       <= 1'b0;
      fvld      <= 1'b0;
      busy      <= 1'b0;
      have_prev <= 1'b0;
`ifdef IQ_MAG_EN
      mag       <= '0;
`endif
    end else begin
      rdy <= 1'b0;
      if (bus.stb && bus.iq) begin
        hold_i <= bus.dixy;
        hold_v <= 1'b1;
      end else if (pair) begin
        hold_v <= 1'b0;
        cnt    <= cnt + 1'b1;
        if (cnt == '0 && state == IDLE) begin
          pair_i <= hold_i;
          pair_q <= bus.dixy;
          busy   <= 1'b1;
          state  <= PRE;
        end
      end
      case (state)
        IDLE: ;
        PRE: begin
          // fold the left half-plane onto the right, remember the pi
          if (pair_i[17]) begin
            x <= -ie;
            y <= -qe;
            z <= 16'h8000;
          end else begin
            x <= ie;
            y <= qe;
            z <= 16'h0000;
          end
          k     <= '0;
          state <= ROT;
        end
        ROT: begin
          if (y[W-1]) begin
            x <= x - (y >>> k);
            y <= y + (x >>> k);
            z <= z - atan_lut(k);
          end else begin
            x <= x + (y >>> k);
            y <= y - (x >>> k);
            z <= z + atan_lut(k);
          end
          k <= k + 1'b1;
          if (k == 5'(ITER - 1)) state <= OUT;
        end
        OUT: begin
          phs <= z;
          if (have_prev) frq <= {{16{d[15]}}, d} << (16 - DECLOG2);
          fvld      <= have_prev;
          have_prev <= 1'b1;
`ifdef IQ_MAG_EN
          mag       <= x[20:2];
`endif
          rdy   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
